// File: rtl/mac_engine_nlane_pkg.sv
// Shared types for the multi-lane MAC engine: job mode, FSM state, latched job
// configuration and the status flags reported back to the controller.
package mac_package;

  localparam int MAC_CNT_W   = 16;
  localparam int MAC_ACC_W   = 40;
  localparam int MAC_SHIFT_W = $clog2(MAC_ACC_W);

  typedef enum logic {
    MAC_MUL = 1'b0,
    MAC_ACC = 1'b1
  } mac_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nlane_state_t;

  typedef struct packed {
    logic [MAC_CNT_W-1:0]   len;
    mac_mode_t              mode;
    logic [MAC_SHIFT_W-1:0] shift;
    logic                   sat_en;
  } ctrl_engine_nlane_t;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [MAC_CNT_W-1:0] cnt;
  } flags_engine_nlane_t;

endpackage

// File: rtl/mac_engine_nlane_if.sv
// Stream bundle between the streamer and the MAC engine: a/b/c sources, d sink.
// The master side is the streamer, the slave side is the engine.
interface mac_engine_nlane_if #(
  parameter int N_LANES = 4,
  parameter int DATA_W  = 16,
  parameter int OUT_W   = 32
) ();

  logic                       a_valid;
  logic                       a_ready;
  logic [N_LANES*DATA_W-1:0]  a_data;
  logic                       b_valid;
  logic                       b_ready;
  logic [N_LANES*DATA_W-1:0]  b_data;
  logic                       c_valid;
  logic                       c_ready;
  logic [N_LANES*OUT_W-1:0]   c_data;
  logic                       d_valid;
  logic                       d_ready;
  logic [N_LANES*OUT_W-1:0]   d_data;

  modport master (
    output a_valid, a_data, b_valid, b_data, c_valid, c_data, d_ready,
    input  a_ready, b_ready, c_ready, d_valid, d_data
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, c_valid, c_data, d_ready,
    output a_ready, b_ready, c_ready, d_valid, d_data
  );

endinterface

// File: rtl/mac_engine_nlane_lane.sv
// One MAC lane: S1 product/addend capture, S2 accumulate or multiply-add,
// arithmetic shift and saturate-or-wrap into the lane's output register.
module mac_nlane_lane
  import mac_package::*;
#(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 40,
  parameter int OUT_W   = 32,
  parameter int SHIFT_W = $clog2(ACC_W)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     load_i,
  input  logic                     step_i,
  input  logic                     last_i,
  input  mac_mode_t                mode_i,
  input  logic [SHIFT_W-1:0]       shift_i,
  input  logic                     sat_en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic signed [OUT_W-1:0]  c_i,
  output logic signed [OUT_W-1:0]  d_o
);

  localparam int P_W = 2 * DATA_W;

  logic signed [P_W-1:0]   a_ext;
  logic signed [P_W-1:0]   b_ext;
  logic signed [P_W-1:0]   prod;
  logic signed [P_W-1:0]   p_q;
  logic signed [OUT_W-1:0] c_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] p_sh;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [ACC_W:0]   mul_sum;
  logic signed [ACC_W:0]   acc_wide;
  logic signed [OUT_W-1:0] d_next;

  // A value fits OUT_W when every bit above the output sign bit repeats the sign.
  function automatic logic signed [OUT_W-1:0] fit(input logic signed [ACC_W:0] v,
                                                   input logic sat);
    logic fits;
    fits = (v[ACC_W:OUT_W-1] == {(ACC_W-OUT_W+2){v[ACC_W]}});
    if (!sat || fits) return v[OUT_W-1:0];
    else if (v[ACC_W]) return {1'b1, {(OUT_W-1){1'b0}}};
    else return {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  always_comb begin
    a_ext    = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    b_ext    = {{DATA_W{b_i[DATA_W-1]}}, b_i};
    prod     = a_ext * b_ext;
    p_ext    = {{(ACC_W-P_W){p_q[P_W-1]}}, p_q};
    p_sh     = p_ext >>> shift_i;
    mul_sum  = {{(ACC_W+1-OUT_W){c_q[OUT_W-1]}}, c_q} + {p_sh[ACC_W-1], p_sh};
    acc_sum  = acc_q + p_ext;
    acc_sh   = acc_sum >>> shift_i;
    acc_wide = {acc_sh[ACC_W-1], acc_sh};
    d_next   = (mode_i == MAC_ACC) ? fit(acc_wide, sat_en_i) : fit(mul_sum, sat_en_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q   <= '0;
      c_q   <= '0;
      acc_q <= '0;
      d_o   <= '0;
    end else begin
      if (load_i) begin
        p_q <= prod;
        c_q <= c_i;
      end
      if (clear_i) begin
        acc_q <= '0;
      end else if (step_i && mode_i == MAC_ACC) begin
        acc_q <= last_i ? '0 : acc_sum;
      end
      if (!clear_i && step_i && (mode_i == MAC_MUL || last_i)) begin
        d_o <= d_next;
      end
    end
  end

endmodule

// File: rtl/mac_engine_nlane.sv
// N-lane signed MAC engine: job FSM, beat counter, stream handshake join and
// output valid control around N_LANES mac_nlane_lane datapaths.
//
//   state | meaning
//   IDLE  | waiting for start_i; config latched on start
//   RUN   | accepting beats and emitting results on d
//   DONE  | one cycle, done_o high, then back to IDLE
module mac_engine_nlane
  import mac_package::*;
#(
  parameter int N_LANES = 4,
  parameter int DATA_W  = 16,
  parameter int ACC_W   = MAC_ACC_W,
  parameter int OUT_W   = 32,
  parameter int CNT_W   = MAC_CNT_W,
  parameter int SHIFT_W = $clog2(ACC_W)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [CNT_W-1:0]    len_i,
  input  logic                mode_i,
  input  logic [SHIFT_W-1:0]  shift_i,
  input  logic                sat_en_i,
  mac_engine_nlane_if.slave   strm,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    cnt_o
);

  nlane_state_t            state_q;
  nlane_state_t            state_d;
  ctrl_engine_nlane_t      cfg_q;
  flags_engine_nlane_t     flags;
  logic [CNT_W-1:0]        cnt_q;
  logic                    start_ok;
  logic                    en;
  logic                    fire;
  logic                    last_beat;
  logic                    s1_valid_q;
  logic                    s1_last_q;
  logic                    s2_out;
  logic                    d_valid_q;
  logic                    d_last_q;
  logic                    d_hs;
  logic [N_LANES*OUT_W-1:0] d_data;

  assign start_ok  = (state_q == IDLE) && start_i && !clear_i;
  assign en        = !d_valid_q || strm.d_ready;
  assign fire      = (state_q == RUN) && en && (cnt_q < cfg_q.len) &&
                     strm.a_valid && strm.b_valid &&
                     (strm.c_valid || cfg_q.mode == MAC_ACC);
  assign last_beat = (cnt_q == cfg_q.len - CNT_W'(1));
  // ACC produces a single result per job, on the last beat only.
  assign s2_out    = s1_valid_q && (cfg_q.mode == MAC_MUL || s1_last_q);
  assign d_hs      = d_valid_q && strm.d_ready;

  assign strm.a_ready = fire;
  assign strm.b_ready = fire;
  assign strm.c_ready = fire && (cfg_q.mode == MAC_MUL);
  assign strm.d_valid = d_valid_q;
  assign strm.d_data  = d_data;

  assign flags  = '{busy: (state_q != IDLE), done: (state_q == DONE), cnt: cnt_q};
  assign busy_o = flags.busy;
  assign done_o = flags.done;
  assign cnt_o  = flags.cnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = (len_i == '0) ? DONE : RUN;
      RUN:     if (d_hs && d_last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q <= '0;
    end else if (start_ok) begin
      cfg_q <= '{len: len_i, mode: mac_mode_t'(mode_i), shift: shift_i, sat_en: sat_en_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      d_last_q   <= 1'b0;
    end else if (clear_i) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      d_last_q   <= 1'b0;
    end else begin
      if (start_ok)  cnt_q <= '0;
      else if (fire) cnt_q <= cnt_q + CNT_W'(1);
      if (en) begin
        s1_valid_q <= fire;
        s1_last_q  <= fire && last_beat;
        d_valid_q  <= s2_out;
        d_last_q   <= s1_last_q;
      end
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    mac_nlane_lane #(
      .DATA_W  (DATA_W),
      .ACC_W   (ACC_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .load_i   (fire),
      .step_i   (en && s1_valid_q),
      .last_i   (s1_last_q),
      .mode_i   (cfg_q.mode),
      .shift_i  (cfg_q.shift),
      .sat_en_i (cfg_q.sat_en),
      .a_i      (strm.a_data[i*DATA_W +: DATA_W]),
      .b_i      (strm.b_data[i*DATA_W +: DATA_W]),
      .c_i      (strm.c_data[i*OUT_W +: OUT_W]),
      .d_o      (d_data[i*OUT_W +: OUT_W])
    );
  end

endmodule
